// File: rtl/booth_inverse_divider_pkg.sv
// div_pkg: shared FSM states, error codes and magnitude helper for the inverse divider
package div_pkg;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam int MAG_W = 129;
  function automatic logic [MAG_W-1:0] abs_val(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? ~v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/booth_inverse_divider_div_restore_step.sv
// div_restore_step: one restoring-division step (shift in a dividend bit, conditionally subtract)
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic             din,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_next,
  output logic             q
);
  localparam int SW = WIDTH + 2;
  localparam int NW = WIDTH + 1;
  logic [WIDTH+1:0] shifted;
  assign shifted = {partial, din};
  assign q = shifted >= SW'(dmag);
  assign rem_next = NW'(q ? shifted - SW'(dmag) : shifted);
endmodule

// File: rtl/booth_inverse_divider.sv
// booth_inverse_divider: sequential signed restoring divider recovering x from (x*y, y)
module booth_inverse_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic [1:0]           err
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_next;
  logic [DW-1:0] dvd, dmag_c;
  logic [WIDTH-1:0] dvs, ymag_c, ymag, lo, qmag;
  logic [WIDTH:0] partial, step_next;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, step_q, div0, ovf_prep, ovf_fix;
  assign dmag_c = DW'(abs_val(MAG_W'($signed(dvd))));
  assign ymag_c = WIDTH'(abs_val(MAG_W'($signed(dvs))));
  assign div0 = dvs == '0;
  assign ovf_prep = dmag_c[DW-1:WIDTH] >= ymag_c;
  assign ovf_fix = sign_q ? (qmag[WIDTH-1] && |qmag[WIDTH-2:0]) : qmag[WIDTH-1];
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .partial  (partial),
    .din      (lo[WIDTH-1]),
    .dmag     (ymag),
    .rem_next (step_next),
    .q        (step_q)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = in_valid ? PREP : IDLE;
      PREP: state_next = (div0 || ovf_prep) ? DONE : CALC;
      CALC: state_next = (cnt == '0) ? FIX : CALC;
      FIX: state_next = DONE;
      DONE: state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // datapath: operand capture, magnitude prep, restoring steps, sign fix-up
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      partial <= '0;
      lo <= '0;
      qmag <= '0;
      ymag <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      err <= ERR_OK;
    end else begin
      if (state == IDLE && in_valid) begin
        dvd <= dividend;
        dvs <= divisor;
        sign_q <= dividend[DW-1] ^ divisor[WIDTH-1];
        sign_r <= dividend[DW-1];
      end
      if (state == PREP) begin
        partial <= {1'b0, dmag_c[DW-1:WIDTH]};
        lo <= dmag_c[WIDTH-1:0];
        ymag <= ymag_c;
        qmag <= '0;
        cnt <= CW'(WIDTH - 1);
        if (div0) begin
          quotient <= '1;
          remainder <= dvd[WIDTH-1:0];
          err <= ERR_DIV0;
        end else if (ovf_prep) begin
          quotient <= Q_MIN;
          remainder <= '0;
          err <= ERR_OVF;
        end
      end
      if (state == CALC) begin
        partial <= step_next;
        lo <= {lo[WIDTH-2:0], 1'b0};
        qmag <= {qmag[WIDTH-2:0], step_q};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        quotient <= ovf_fix ? Q_MIN : (sign_q ? -qmag : qmag);
        remainder <= ovf_fix ? '0 : (sign_r ? -partial[WIDTH-1:0] : partial[WIDTH-1:0]);
        err <= ovf_fix ? ERR_OVF : ERR_OK;
      end
    end
endmodule

// File: tb/tb_booth_inverse_divider.sv
// tb_booth_inverse_divider: directed and product-based checks of the inverse divider
module tb_booth_inverse_divider;
  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, in_ready, out_valid;
  logic [63:0] dividend;
  logic [31:0] divisor, quotient, remainder;
  logic [1:0] err;
  int tests = 0;
  int fails = 0;

  booth_inverse_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  // issue one operation with out_ready high; lat = edges after accept until out_valid, -1 on timeout
  task automatic run_op(input logic [63:0] p, input logic [31:0] y, output logic [31:0] q,
                        output logic [31:0] r, output logic [1:0] e, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1; dividend = p; divisor = y; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!out_valid || n >= 200) lat = -1;
    q = quotient; r = remainder; e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || err !== 2'b00) begin
      fails++;
      $display("FAIL reset_asserted: in_ready=%b out_valid=%b q=%h r=%h err=%b, want 1 0 0 0 00", in_ready, out_valid, quotient, remainder, err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 2'b00) begin
      fails++;
      $display("FAIL reset_released: in_ready=%b out_valid=%b err=%b, want 1 0 00", in_ready, out_valid, err);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q, r; logic [1:0] e; int lat;
    run_op(64'd225, 32'd15, q, r, e, lat);
    tests++;
    if (q !== 32'd15 || r !== 32'd0 || e !== 2'b00 || lat !== 34) begin
      fails++;
      $display("FAIL div_225_15: q=%0d r=%0d err=%b lat=%0d, want 15 0 00 34", q, r, e, lat);
    end
  endtask

  task automatic test_signs();
    logic [31:0] q, r; logic [1:0] e; int lat;
    run_op(-64'sd225, 32'd15, q, r, e, lat);
    tests++;
    if (q !== 32'hFFFF_FFF1 || r !== 32'd0 || e !== 2'b00) begin
      fails++;
      $display("FAIL div_m225_15: q=%h r=%h err=%b, want fffffff1 0 00", q, r, e);
    end
    run_op(64'd100, -32'sd7, q, r, e, lat);
    tests++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'd2 || e !== 2'b00) begin
      fails++;
      $display("FAIL div_100_m7: q=%h r=%h err=%b, want fffffff2 2 00", q, r, e);
    end
    run_op(-64'sd100, 32'd7, q, r, e, lat);
    tests++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || e !== 2'b00) begin
      fails++;
      $display("FAIL div_m100_7: q=%h r=%h err=%b, want fffffff2 fffffffe 00", q, r, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] q, r; logic [1:0] e; int lat;
    run_op(64'd7, 32'd0, q, r, e, lat);
    tests++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd7 || e !== 2'b01 || lat < 1 || lat > 2) begin
      fails++;
      $display("FAIL div_by_zero: q=%h r=%h err=%b lat=%0d, want ffffffff 7 01 lat<=2", q, r, e, lat);
    end
    run_op(64'h0000_0100_0000_0000, 32'd2, q, r, e, lat);
    tests++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 2'b10 || lat < 1 || lat > 2) begin
      fails++;
      $display("FAIL ovf_prep: q=%h r=%h err=%b lat=%0d, want 80000000 0 10 lat<=2", q, r, e, lat);
    end
    run_op(64'hFFFF_FFFF_0000_0000, 32'd2, q, r, e, lat);
    tests++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 2'b00 || lat !== 34) begin
      fails++;
      $display("FAIL neg_limit: q=%h r=%h err=%b lat=%0d, want 80000000 0 00 34", q, r, e, lat);
    end
    run_op(64'h0000_0000_8000_0000, 32'd1, q, r, e, lat);
    tests++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 2'b10 || lat !== 34) begin
      fails++;
      $display("FAIL ovf_fix_pos: q=%h r=%h err=%b lat=%0d, want 80000000 0 10 34", q, r, e, lat);
    end
    run_op(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, q, r, e, lat);
    tests++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 2'b10) begin
      fails++;
      $display("FAIL ovf_min_dividend: q=%h r=%h err=%b, want 80000000 0 10", q, r, e);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic bad = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1; dividend = 64'd1000; divisor = 32'd3; out_ready = 1'b0;
    @(negedge clk);
    dividend = 64'd50; divisor = 32'd5;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd333 || remainder !== 32'd1 || err !== 2'b00) bad = 1'b1;
    end
    tests++;
    if (bad || n >= 200) begin
      fails++;
      $display("FAIL hold_stable: out_valid=%b in_ready=%b q=%0d r=%0d, want 1 0 333 1 held", out_valid, in_ready, quotient, remainder);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (quotient !== 32'd10 || remainder !== 32'd0 || n !== 34) begin
      fails++;
      $display("FAIL second_op: q=%0d r=%0d lat=%0d, want 10 0 34", quotient, remainder, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic [1:0] e; int lat;
    logic stale = 1'b0;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1; dividend = 64'd12345; divisor = 32'd7; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || err !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b q=%h r=%h err=%b, want 1 0 0 0 00", in_ready, out_valid, quotient, remainder, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    tests++;
    if (stale) begin
      fails++;
      $display("FAIL stale_valid: out_valid=1 after reset, want 0");
    end
    run_op(64'd1000, 32'd3, q, r, e, lat);
    tests++;
    if (q !== 32'd333 || r !== 32'd1 || e !== 2'b00 || lat !== 34) begin
      fails++;
      $display("FAIL post_reset_op: q=%0d r=%0d err=%b lat=%0d, want 333 1 00 34", q, r, e, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] q, r, eq, er; logic [1:0] e, ee; int lat;
    int xv, yv;
    longint pl, yl, qe, re;
    logic ok;
    for (int i = 0; i < 1000; i++) begin
      xv = $urandom;
      yv = $urandom;
      if (i % 8 == 0) yv = int'($urandom_range(0, 3)) - 1;
      if (i % 16 == 1) xv = 32'h8000_0000;
      pl = longint'(xv) * longint'(yv);
      yl = longint'(yv);
      if (yv == 0) begin
        eq = 32'hFFFF_FFFF; er = pl[31:0]; ee = 2'b01;
      end else begin
        qe = pl / yl;
        re = pl % yl;
        if (qe > 64'sd2147483647 || qe < -64'sd2147483648) begin
          eq = 32'h8000_0000; er = '0; ee = 2'b10;
        end else begin
          eq = qe[31:0]; er = re[31:0]; ee = 2'b00;
        end
      end
      run_op(pl, yv, q, r, e, lat);
      ok = (q === eq) && (r === er) && (e === ee) && (lat >= 0);
      if (e === 2'b00) ok = ok && (longint'($signed(q)) * yl + longint'($signed(r)) == pl);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL random_%0d: p=%h y=%h q=%h r=%h err=%b lat=%0d, want q=%h r=%h err=%b", i, pl, yv, q, r, e, lat, eq, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
